// File: rtl/sr_ff.sv
`timescale 1ns/10ps
// Clocked SR flip-flop bank: WIDTH independent set/reset storage bits with complementary outputs.
// Latency: q updates on the rising edge that samples S/R; an asynchronous reset clears it immediately.
// Backpressure: none. The block always accepts S/R and always presents q/qn.
module sr_ff #(
  parameter int                WIDTH        = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL    = '0,
  parameter int                INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  // S=R=1 policy. Any value other than 1 or 2 falls back to hold.
  localparam bit RST_DOM = (INVALID_MODE == 1);
  localparam bit SET_DOM = (INVALID_MODE == 2);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_both_val;
  logic [WIDTH-1:0] w_next;

  // Per-bit next state: set wins alone, reset wins alone, conflict per policy, otherwise hold.
  always_comb begin
    w_both_val = r_q;
    if (RST_DOM) begin
      w_both_val = '0;
    end else if (SET_DOM) begin
      w_both_val = '1;
    end
    w_next = (S & ~R) | (~S & ~R & r_q) | (S & R & w_both_val);
  end

  // State register; reset forces RESET_VAL at once and masks S/R while held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_next;
    end
  end

  // qn is taken straight from the register so it can never disagree with q.
  assign q  = r_q;
  assign qn = ~r_q;

endmodule

// File: tb/tb_sr_ff.sv
`timescale 1ns/10ps
// Testbench for sr_ff: three single-bit instances (one per conflict policy) and one 4-bit instance
// with a non-zero reset value and an out-of-range policy, all driven from shared stimulus.
module tb_sr_ff;

  logic       clk;
  logic       reset;
  logic [0:0] s1, r1;
  logic [3:0] s4, r4;
  logic [0:0] q_m0, qn_m0, q_m1, qn_m1, q_m2, qn_m2;
  logic [3:0] q_w4, qn_w4;

  localparam logic [3:0] W4_RST = 4'b0110;

  sr_ff #(.WIDTH(1), .RESET_VAL(1'b0), .INVALID_MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_m0), .qn(qn_m0));
  sr_ff #(.WIDTH(1), .RESET_VAL(1'b0), .INVALID_MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_m1), .qn(qn_m1));
  sr_ff #(.WIDTH(1), .RESET_VAL(1'b0), .INVALID_MODE(2)) u_m2 (
    .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_m2), .qn(qn_m2));
  sr_ff #(.WIDTH(4), .RESET_VAL(W4_RST), .INVALID_MODE(3)) u_w4 (
    .clk(clk), .reset(reset), .S(s4), .R(r4), .q(q_w4), .qn(qn_w4));

  typedef struct {
    int         ph;
    logic       q0;
    logic       q1;
    logic       q2;
    logic [3:0] q4;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference state
  logic       m0, m1, m2;
  logic [3:0] m4;
  int         phase = 0;

  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  // Behavioural SR rule applied bit by bit.
  function automatic logic [3:0] sr_next(input logic [3:0] cur, input logic [3:0] s,
                                         input logic [3:0] r, input int mode, input int w);
    logic [3:0] n;
    n = cur;
    for (int i = 0; i < w; i++) begin
      if (s[i] && !r[i])      n[i] = 1'b1;
      else if (!s[i] && r[i]) n[i] = 1'b0;
      else if (s[i] && r[i]) begin
        if (mode == 1)      n[i] = 1'b0;
        else if (mode == 2) n[i] = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    m0 = 1'b0; m1 = 1'b0; m2 = 1'b0; m4 = W4_RST;
  endtask

  task automatic model_step();
    logic [3:0] t;
    t = sr_next({3'b0, m0}, {3'b0, s1}, {3'b0, r1}, 0, 1); m0 = t[0];
    t = sr_next({3'b0, m1}, {3'b0, s1}, {3'b0, r1}, 1, 1); m1 = t[0];
    t = sr_next({3'b0, m2}, {3'b0, s1}, {3'b0, r1}, 2, 1); m2 = t[0];
    m4 = sr_next(m4, s4, r4, 3, 4);
  endtask

  task automatic push_exp();
    exp_t e;
    e.ph = phase; e.q0 = m0; e.q1 = m1; e.q2 = m2; e.q4 = m4;
    sb.push_back(e);
  endtask

  // One clock cycle of stimulus. rst is a level held through the next edge;
  // pulse raises reset briefly between edges and drops it before the next edge.
  task automatic cycle(input bit rst, input bit pulse, input logic s, input logic r,
                       input logic [3:0] ss, input logic [3:0] rr);
    @(negedge clk);
    #0.1;
    if (pulse) begin
      model_reset();
      push_exp();
      reset = 1'b1;
      s1 = s; r1 = r; s4 = ss; r4 = rr;
      #0.6;
      reset = 1'b0;
      model_step();
      push_exp();
    end else begin
      if (rst && !reset) begin
        model_reset();
        push_exp();
      end
      reset = rst;
      s1 = s; r1 = r; s4 = ss; r4 = rr;
      if (rst) model_reset();
      else     model_step();
      push_exp();
    end
  endtask

  task automatic check(input string name, input int ph, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s phase %0d: got %b, expected %b", name, ph, act, req);
    end
  endtask

  // Monitor: samples after every clock edge and every reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #0.5;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("q_m0",  e.ph, {3'b0, q_m0},  {3'b0, e.q0});
        check("qn_m0", e.ph, {3'b0, qn_m0}, {3'b0, ~e.q0});
        check("q_m1",  e.ph, {3'b0, q_m1},  {3'b0, e.q1});
        check("qn_m1", e.ph, {3'b0, qn_m1}, {3'b0, ~e.q1});
        check("q_m2",  e.ph, {3'b0, q_m2},  {3'b0, e.q2});
        check("qn_m2", e.ph, {3'b0, qn_m2}, {3'b0, ~e.q2});
        check("q_w4",  e.ph, q_w4,  e.q4);
        check("qn_w4", e.ph, qn_w4, ~e.q4);
      end
    end
  end

  initial begin
    reset = 1'b1;
    s1 = '0; r1 = '0; s4 = '0; r4 = '0;
    model_reset();

    // 1: reset held, every S/R pattern ignored
    phase = 1;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 3; k++) begin
        case (p)
          0:       cycle(1, 0, 1, 0, 4'hF, 4'h0);
          1:       cycle(1, 0, 0, 1, 4'h0, 4'hF);
          2:       cycle(1, 0, 0, 0, 4'h0, 4'h0);
          default: cycle(1, 0, 1, 1, 4'hF, 4'hF);
        endcase
      end
    end

    // 3: set / reset / hold / set
    phase = 3;
    cycle(0, 0, 1, 0, 4'h1, 4'h0);
    cycle(0, 0, 0, 1, 4'h0, 4'h1);
    cycle(0, 0, 0, 0, 4'h0, 4'h0);
    cycle(0, 0, 1, 0, 4'h8, 4'h0);

    // 2: asynchronous reset pulse between edges, then hold and set again
    phase = 2;
    cycle(0, 1, 0, 0, 4'h0, 4'h0);
    cycle(0, 0, 1, 0, 4'h1, 4'h0);

    // 4: conflicting requests for three edges from q=1
    phase = 4;
    cycle(0, 0, 1, 0, 4'hF, 4'h0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 4'hF, 4'hF);

    // 6: multi-bit independence
    phase = 6;
    cycle(0, 0, 0, 0, 4'b1010, 4'b0101);
    cycle(0, 0, 0, 0, 4'b0000, 4'b1000);

    // 5: random S/R with random level and pulsed resets
    phase = 5;
    for (int k = 0; k < 200; k++) begin
      cycle(($urandom_range(31) == 0), ($urandom_range(15) == 0),
            1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    end
    cycle(0, 0, 0, 0, 4'h0, 4'h0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
